// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t : controller state encoding (RUN, DRAIN, HALTED)
//   CNT_W   : width of the performance counters
//   REG_W   : width of a register specifier
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned REG_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection, purely combinational.
//   ex_memtoreg : ID/EX instruction is a load
//   ex_DstReg   : its destination register
//   id_SrcReg1/2, id_use1/2 : ID-stage source registers and valid flags
//   load_use    : ID instruction consumes the load result next cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_memtoreg,
  input  logic [REG_W-1:0] ex_DstReg,
  input  logic [REG_W-1:0] id_SrcReg1,
  input  logic [REG_W-1:0] id_SrcReg2,
  input  logic             id_use1,
  input  logic             id_use2,
  output logic             load_use
);

  logic hit1;
  logic hit2;

  always_comb begin
    hit1     = id_use1 && (id_SrcReg1 == ex_DstReg);
    hit2     = id_use2 && (id_SrcReg2 == ex_DstReg);
    // R0 is hard-wired zero, so a load into it never creates a dependency
    load_use = ex_memtoreg && (ex_DstReg != '0) && (hit1 || hit2);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritised freeze/flush generation, halt
// sequencing (RUN -> DRAIN -> HALTED) and stall/flush performance counters.
//   clk, rst (async, active low)
//   icache_stall, dcache_stall : cache miss busy
//   ex_memtoreg, ex_DstReg, id_SrcReg1/2, id_use1/2 : load-use operands
//   branch_taken, id_halt, wb_halt : control-flow events
//   *_freeze, *_flush : per pipeline register hold / nop controls
//   halted : processor stopped
//   stall_cnt, flush_cnt : saturating performance counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             ex_memtoreg,
  input  logic [REG_W-1:0] ex_DstReg,
  input  logic [REG_W-1:0] id_SrcReg1,
  input  logic [REG_W-1:0] id_SrcReg2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             branch_taken,
  input  logic             id_halt,
  input  logic             wb_halt,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_freeze,
  output logic             id_ex_flush,
  output logic             ex_mem_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t state;
  state_t state_nxt;
  logic   load_use;

  hazard_detect u_hazard_detect (
    .ex_memtoreg (ex_memtoreg),
    .ex_DstReg   (ex_DstReg),
    .id_SrcReg1  (id_SrcReg1),
    .id_SrcReg2  (id_SrcReg2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state. wb_halt means the HLT has already retired, so it wins over
  // any younger branch; a branch stalled behind a D-miss is not yet final.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (wb_halt) begin
          state_nxt = HALTED;
        end else if (id_halt && !branch_taken && !dcache_stall) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (wb_halt) begin
          state_nxt = HALTED;
        end else if (branch_taken && !dcache_stall) begin
          state_nxt = RUN;
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // Priority mux; outputs are forced low while reset is asserted so they
  // clear immediately rather than at the next edge.
  always_comb begin
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_freeze  = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_freeze = 1'b0;
    if (rst) begin
      if (state == HALTED || dcache_stall) begin
        pc_freeze     = 1'b1;
        if_id_freeze  = 1'b1;
        id_ex_freeze  = 1'b1;
        ex_mem_freeze = 1'b1;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (icache_stall || state == DRAIN) begin
        pc_freeze   = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

  always_comb begin
    halted = (state == HALTED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != HALTED && pc_freeze && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (branch_taken && !dcache_stall && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        icache_stall, dcache_stall, ex_memtoreg;
  logic [3:0]  ex_DstReg, id_SrcReg1, id_SrcReg2;
  logic        id_use1, id_use2, branch_taken, id_halt, wb_halt;
  logic        pc_freeze, if_id_freeze, if_id_flush;
  logic        id_ex_freeze, id_ex_flush, ex_mem_freeze, halted;
  logic [15:0] stall_cnt, flush_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  pipe_hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .icache_stall  (icache_stall),
    .dcache_stall  (dcache_stall),
    .ex_memtoreg   (ex_memtoreg),
    .ex_DstReg     (ex_DstReg),
    .id_SrcReg1    (id_SrcReg1),
    .id_SrcReg2    (id_SrcReg2),
    .id_use1       (id_use1),
    .id_use2       (id_use2),
    .branch_taken  (branch_taken),
    .id_halt       (id_halt),
    .wb_halt       (wb_halt),
    .pc_freeze     (pc_freeze),
    .if_id_freeze  (if_id_freeze),
    .if_id_flush   (if_id_flush),
    .id_ex_freeze  (id_ex_freeze),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_freeze (ex_mem_freeze),
    .halted        (halted),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model. Control word order:
  // {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush, ex_mem_freeze}
  // Model state: 0 = running, 1 = draining, 2 = stopped.
  int m_state = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic [5:0] exp_ctl(input int st);
    bit lu;
    lu = ex_memtoreg && ex_DstReg != 0 &&
         ((id_use1 && id_SrcReg1 == ex_DstReg) || (id_use2 && id_SrcReg2 == ex_DstReg));
    if (!rst)                 return 6'b000000;
    if (st == 2)              return 6'b110101;
    if (dcache_stall)         return 6'b110101;
    if (branch_taken)         return 6'b001010;
    if (lu)                   return 6'b110010;
    if (icache_stall)         return 6'b101000;
    if (st == 1)              return 6'b101000;
    return 6'b000000;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      logic [5:0] c;
      c = exp_ctl(m_state);
      if (m_state != 2 && c[5] && m_stall < 65535) m_stall++;
      if (branch_taken && !dcache_stall && m_flush < 65535) m_flush++;
      if (m_state == 0) begin
        if (wb_halt) m_state = 2;
        else if (id_halt && !branch_taken && !dcache_stall) m_state = 1;
      end else if (m_state == 1) begin
        if (wb_halt) m_state = 2;
        else if (branch_taken && !dcache_stall) m_state = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("ctl_vec", {26'd0, pc_freeze, if_id_freeze, if_id_flush,
                      id_ex_freeze, id_ex_flush, ex_mem_freeze},
          {26'd0, exp_ctl(m_state)});
    check("halted", {31'd0, halted}, {31'd0, m_state == 2});
    check("stall_cnt", {16'd0, stall_cnt}, m_stall);
    check("flush_cnt", {16'd0, flush_cnt}, m_flush);
  end

  task automatic clr_in();
    icache_stall = 0; dcache_stall = 0; ex_memtoreg = 0;
    ex_DstReg = 0; id_SrcReg1 = 0; id_SrcReg2 = 0;
    id_use1 = 0; id_use2 = 0; branch_taken = 0; id_halt = 0; wb_halt = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    clr_in();
    do_reset();
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_halted", halted, 0);

    // Load-use: one bubble
    ex_memtoreg = 1; ex_DstReg = 3; id_use1 = 1; id_SrcReg1 = 3;
    #2;
    check("lu_pc_freeze", pc_freeze, 1);
    check("lu_if_id_freeze", if_id_freeze, 1);
    check("lu_id_ex_flush", id_ex_flush, 1);
    next_cyc();
    clr_in();
    #2;
    check("lu_release", pc_freeze, 0);
    check("lu_stall_cnt", stall_cnt, 1);

    // Load into R0 never stalls
    do_reset();
    ex_memtoreg = 1; ex_DstReg = 0; id_use1 = 1; id_SrcReg1 = 0;
    #2;
    check("r0_pc_freeze", pc_freeze, 0);
    next_cyc();
    clr_in();
    #2;
    check("r0_stall_cnt", stall_cnt, 0);

    // D-miss overlapping a branch: branch deferred
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dcache_stall = 1; branch_taken = 1;
      #2;
      check("dm_freezes", {pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze}, 4'b1111);
      check("dm_flushes", {if_id_flush, id_ex_flush}, 2'b00);
      next_cyc();
    end
    dcache_stall = 0;
    #2;
    check("dm_br_flushes", {if_id_flush, id_ex_flush}, 2'b11);
    next_cyc();
    clr_in();
    #2;
    check("dm_flush_cnt", flush_cnt, 1);
    check("dm_stall_cnt", stall_cnt, 5);

    // Branch during an I-miss: target must load
    do_reset();
    icache_stall = 1; branch_taken = 1;
    #2;
    check("im_br_pc_freeze", pc_freeze, 0);
    check("im_br_flushes", {if_id_flush, id_ex_flush}, 2'b11);
    next_cyc();
    clr_in();

    // Halt drain
    do_reset();
    id_halt = 1;
    next_cyc();
    id_halt = 0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) wb_halt = 1;
      #2;
      check("drain_pc_freeze", pc_freeze, 1);
      check("drain_halted", halted, 0);
      next_cyc();
    end
    wb_halt = 0;
    branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("halt_halted", halted, 1);
      check("halt_freezes", {pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze}, 4'b1111);
      next_cyc();
    end
    clr_in();
    #2;
    check("halt_stall_cnt", stall_cnt, 3);

    // Cancelled halt, then async reset mid-DRAIN
    do_reset();
    id_halt = 1;
    next_cyc();
    id_halt = 0; branch_taken = 1;
    #2;
    check("cx_drain_branch", {if_id_flush, id_ex_flush, pc_freeze}, 3'b110);
    next_cyc();
    branch_taken = 0;
    #2;
    check("cx_run_pc_freeze", pc_freeze, 0);
    check("cx_run_halted", halted, 0);
    id_halt = 1;
    next_cyc();
    id_halt = 0;
    #2;
    check("cx_drain2", pc_freeze, 1);
    #1;
    rst = 0;
    #1;
    check("ar_outputs", {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze,
                         id_ex_flush, ex_mem_freeze, halted}, 7'b0);
    check("ar_stall_cnt", stall_cnt, 0);
    check("ar_flush_cnt", flush_cnt, 0);
    next_cyc();
    #2;
    rst = 1;
    next_cyc();
    icache_stall = 1;
    #2;
    check("post_rst_imiss", {pc_freeze, if_id_flush}, 2'b11);
    next_cyc();
    clr_in();
    #2;
    check("post_rst_stall_cnt", stall_cnt, 1);
    next_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
